// File: rtl/usb_gpx_conditioner.sv
`default_nettype none
// ============================================================================
// usb_gpx_conditioner: synchroniser + glitch filter for the MAX3421E GPX pin,
// with an Avalon-MM edge-capture / mask / event-counter slave.
// Rev 1.0
// ============================================================================
module usb_gpx_conditioner #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        gpx_raw,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        gpx_level,
    output logic        irq
);

    localparam logic [7:0] FILT_LAST = 8'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_q;
    logic [7:0]             cnt;
    logic                   lvl_d;
    logic                   rise;
    logic                   fall;
    logic                   edge_any;
    logic [1:0]             mask;
    logic [1:0]             edgecap;
    logic [1:0]             cap_clr;
    logic [15:0]            evcount;
    logic                   bus_wr;
    logic                   unused_wd;

    assign sync_q    = sync_ff[SYNC_STAGES-1];
    assign unused_wd = &{1'b0, writedata[31:2]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], gpx_raw};
        end
    end

    // Level only moves after FILTER_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= 8'd0;
            gpx_level <= RESET_LEVEL;
            lvl_d     <= RESET_LEVEL;
        end else begin
            lvl_d <= gpx_level;
            if (sync_q == gpx_level) begin
                cnt <= 8'd0;
            end else if (cnt == FILT_LAST) begin
                gpx_level <= sync_q;
                cnt       <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign rise     = gpx_level & ~lvl_d;
    assign fall     = ~gpx_level & lvl_d;
    assign edge_any = rise | fall;
    assign bus_wr   = chipselect & ~write_n;

    always_comb begin
        cap_clr = 2'b00;
        if (bus_wr && (address == 2'd2)) begin
            cap_clr = writedata[1:0];
        end
    end

    // New edges are OR-ed in after the W1C so a coincident set wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask    <= 2'b00;
            edgecap <= 2'b00;
            evcount <= 16'd0;
        end else begin
            if (bus_wr && (address == 2'd1)) begin
                mask <= writedata[1:0];
            end
            edgecap <= (edgecap & ~cap_clr) | {fall, rise};
            if (bus_wr && (address == 2'd3)) begin
                evcount <= {15'd0, edge_any};
            end else if (edge_any) begin
                evcount <= evcount + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'd0;
        end else begin
            case (address)
                2'd0:    readdata <= {30'd0, sync_q, gpx_level};
                2'd1:    readdata <= {30'd0, mask};
                2'd2:    readdata <= {30'd0, edgecap};
                default: readdata <= {16'd0, evcount};
            endcase
        end
    end

    assign irq = |(edgecap & mask);

endmodule
`default_nettype wire
